// File: rtl/external_bus_interface_pkg.sv
// Shared types and constants for the external bus interface: FSM state
// encoding, open-bus default and timeout counter width.
package external_bus_interface_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RDY = 2'd2
    } ebi_state_t;

    localparam logic [7:0] OPEN_BUS_DEFAULT  = 8'hFF;
    localparam int         TIMEOUT_CNT_WIDTH = 8;

endpackage

// File: rtl/external_bus_interface_bus_timeout_counter.sv
// Counts REQ cycles without ack; terminalCount flags the last permitted
// cycle so the FSM can abort on that edge.
module bus_timeout_counter
    import external_bus_interface_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic terminalCount
);

    logic [TIMEOUT_CNT_WIDTH-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign terminalCount = (count == TIMEOUT_CNT_WIDTH'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/external_bus_interface.sv
// External bus interface: captures address/write data per bus cycle, runs a
// req/ack memory transaction, stalls the core, and latches read data.
module external_bus_interface
    import external_bus_interface_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 255,
    parameter logic [7:0] OPEN_BUS_VALUE = OPEN_BUS_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cycle_start,
    input  logic        cycle_write,
    input  logic [7:0]  addr_low,
    input  logic [7:0]  addr_high,
    input  logic [7:0]  write_data,
    input  logic        rdy,
    input  logic        clear_error,
    output logic [7:0]  db_read,
    output logic        core_stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic        bus_error
);

    ebi_state_t state, nextState;
    logic       capture, loadRead, loadOpenBus, setError;
    logic       cntClear, cntEnable, timeoutHit;

    bus_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) timeoutCounter (
        .clk          (clk),
        .rst          (rst),
        .clear        (cntClear),
        .enable       (cntEnable),
        .terminalCount(timeoutHit)
    );

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a latch behind.
    always_comb begin
        nextState   = state;
        capture     = 1'b0;
        loadRead    = 1'b0;
        loadOpenBus = 1'b0;
        setError    = 1'b0;
        cntClear    = 1'b0;
        cntEnable   = 1'b0;
        case (state)
            IDLE: begin
                if (cycle_start) begin
                    capture   = 1'b1;
                    cntClear  = 1'b1;
                    nextState = REQ;
                end
            end
            REQ: begin
                // Ack takes priority over a timeout landing on the same edge.
                if (mem_ack) begin
                    if (!mem_we) begin
                        loadRead  = 1'b1;
                        nextState = rdy ? IDLE : WAIT_RDY;
                    end else begin
                        nextState = IDLE;
                    end
                end else if (timeoutHit) begin
                    setError    = 1'b1;
                    loadOpenBus = !mem_we;
                    nextState   = IDLE;
                end else begin
                    cntEnable = 1'b1;
                end
            end
            WAIT_RDY: begin
                if (rdy) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            db_read   <= '0;
            bus_error <= 1'b0;
        end else begin
            state   <= nextState;
            mem_req <= (nextState == REQ);
            if (capture) begin
                mem_addr  <= {addr_high, addr_low};
                mem_we    <= cycle_write;
                mem_wdata <= write_data;
            end
            if (loadRead) begin
                db_read <= mem_rdata;
            end else if (loadOpenBus) begin
                db_read <= OPEN_BUS_VALUE;
            end
            if (setError) begin
                bus_error <= 1'b1;
            end else if (clear_error) begin
                bus_error <= 1'b0;
            end
        end
    end

    // Stall is raised in the same cycle as cycle_start so the core never
    // advances past the start of a bus cycle; forced low during reset.
    assign core_stall = !rst && ((state != IDLE) || cycle_start);

endmodule

// File: doc/external_bus_interface.md
Name: external_bus_interface

Overview:
- Downstream neighbour of the internal dataflow. Consumes the ABH/ABL address outputs and the DOR write data each bus cycle.
- Runs a req/ack transaction to external memory with variable latency, and stalls the core until the transaction finishes.
- Holds read data in a data-input latch that drives the dataflow's external data-bus read input.
- Implements 6502-style RDY semantics: RDY halts reads only. Also provides a timeout with a sticky error flag.

Parameters:
- TIMEOUT_CYCLES, 255: REQ-state cycles without ack before the transaction is aborted. Legal range 1..255.
- OPEN_BUS_VALUE, 8'hFF: value loaded into the data latch when a read times out.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cycle_start  in  1  one-cycle pulse from control: begin a bus cycle
- cycle_write  in  1  1 = write cycle, 0 = read cycle; sampled with cycle_start
- addr_low  in  8  ABL register output
- addr_high  in  8  ABH register output
- write_data  in  8  DOR register output
- rdy  in  1  external ready; low stretches read cycles
- clear_error  in  1  clears bus_error
- db_read  out  8  data-input latch, feeds the dataflow data-bus read input
- core_stall  out  1  core must not advance its timing state while high
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  16  {addr_high, addr_low}, captured
- mem_wdata  out  8  captured write data
- mem_ack  in  1  memory completion
- mem_rdata  in  8  memory read data, valid with mem_ack
- bus_error  out  1  sticky timeout flag

Behaviour:
- Reset (async, rst=1): state IDLE. mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, db_read=0, bus_error=0, timeout count=0.
  - core_stall=0 while in reset.
  - Reset mid-transaction drops mem_req immediately, with no clock edge required.
- States: IDLE, REQ, WAIT_RDY.
- IDLE:
  - When cycle_start=1 at an edge: capture mem_addr={addr_high,addr_low}, mem_we=cycle_write, mem_wdata=write_data. Clear the counter and go to REQ.
  - mem_req is registered; it is high exactly while state==REQ.
- REQ:
  - mem_addr, mem_we and mem_wdata are held stable.
  - On an edge with mem_ack=1:
    - Read: db_read<=mem_rdata. Go to WAIT_RDY if rdy=0, else IDLE.
    - Write: go to IDLE. rdy is ignored for writes.
  - On an edge with mem_ack=0: counter increments. On the edge where the counter reaches TIMEOUT_CYCLES-1 without ack, abort: bus_error<=1, go to IDLE, and for reads only db_read<=OPEN_BUS_VALUE.
  - Ack wins over timeout on the same edge.
- WAIT_RDY: data is held. Go to IDLE on the first edge with rdy=1.
- core_stall is combinational: (state!=IDLE) | (state==IDLE & cycle_start).
- Minimum latency (zero-wait memory, ack in the first REQ cycle): 2 cycles.
  - cycle_start at cycle 0, REQ at cycle 1, IDLE at cycle 2.
  - db_read is valid from cycle 2.
  - core_stall is high in cycles 0 and 1.
- Ignored events:
  - mem_ack outside REQ.
  - cycle_start outside IDLE; the current transaction is unaffected.
- db_read changes only on read completion, read timeout or reset. It is otherwise held across any number of idle cycles.
- bus_error: set on timeout, cleared by clear_error. If set and clear occur on the same edge, set wins.
- mem_addr, mem_we and mem_wdata keep their last values in IDLE.

Decomposition:
- Shared package holds:
  - ebi_state_t enum {IDLE, REQ, WAIT_RDY}
  - OPEN_BUS_VALUE default constant
  - timeout counter width constant (8)
- One sub-module: bus_timeout_counter.
  - Inputs: clear, enable.
  - Output: terminal-count flag.
  - Parameterised by TIMEOUT_CYCLES.
- The FSM and latches stay in the top module.

Test Plan:
- Reset mid-REQ: cycle_start read, then rst=1 before ack → mem_req falls with no clock edge; all outputs zero; state IDLE after release.
- Zero-wait read: addr_high=8'h12, addr_low=8'h34, mem_ack held high, mem_rdata=8'hA5 → mem_addr=16'h1234, mem_req high for 1 cycle, db_read=8'hA5 at cycle 2, core_stall high cycles 0–1.
- Write with 3 wait cycles: write_data=8'h5C, mem_ack on the 4th REQ cycle → mem_we=1, mem_wdata=8'h5C stable for 4 cycles; return to IDLE with db_read unchanged.
- RDY stretch: read with ack in the first REQ cycle, rdy=0 for 5 cycles → WAIT_RDY 5 cycles, core_stall high throughout, db_read holds mem_rdata.
  - Repeat with a write and rdy=0 → no WAIT_RDY entry.
- Timeout: TIMEOUT_CYCLES=4, read, never ack → mem_req high exactly 4 cycles, then db_read=8'hFF and bus_error=1.
  - Assert clear_error together with a second timeout → bus_error stays 1.
  - Assert clear_error alone afterwards → bus_error clears.
- Protocol abuse: cycle_start pulsed during REQ with different addr/data, plus spurious mem_ack in IDLE → captured address and data unchanged, no extra transaction, db_read unchanged.
